// File: rtl/mem_copy_ctrl_if.sv
// Control and address bus between a block-copy requester, mem_copy_ctrl and the two RAMs.
interface mem_copy_ctrl_if #(
    parameter int unsigned AddressWidth = 32
) ();
    logic                    Start;
    logic [AddressWidth-1:0] SrcBase;
    logic [AddressWidth-1:0] DstBase;
    logic [AddressWidth-1:0] Length;
    logic [AddressWidth-1:0] RAddr;
    logic [AddressWidth-1:0] WAddr;
    logic                    WEn;
    logic                    Busy;
    logic                    Done;

    modport master (
        output Start, SrcBase, DstBase, Length,
        input  RAddr, WAddr, WEn, Busy, Done
    );

    modport slave (
        input  Start, SrcBase, DstBase, Length,
        output RAddr, WAddr, WEn, Busy, Done
    );
endinterface

// File: rtl/mem_copy_ctrl.sv
// Block copy engine: streams Length reads from SrcBase and writes each word to DstBase
// ReadLatency cycles later, with the source RAM q wired straight to the destination data.
module mem_copy_ctrl #(
    parameter int unsigned AddressWidth = 32,
    parameter int unsigned ReadLatency  = 1
) (
    input  logic           clk,
    input  logic           aclr,
    mem_copy_ctrl_if.slave bus
);
    localparam int unsigned AW = AddressWidth;
    localparam int unsigned RL = ReadLatency;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

    state_e        state, stateNext;
    logic [AW-1:0] srcQ, srcNext;
    logic [AW-1:0] dstQ, dstNext;
    logic [AW-1:0] lenQ, lenNext;
    logic [AW-1:0] rdIdx, rdIdxNext;
    logic [AW-1:0] wrIdx, wrIdxNext;
    logic [AW-1:0] rAddrQ, rAddrNext;
    logic [AW-1:0] wAddrQ, wAddrNext;
    logic [RL:1]   issuePipe;
    logic [RL:0]   issueVec;
    logic          wEnNext;
    logic          busyQ, busyNext;
    logic          doneQ, doneNext;

    // Stage 0 is the live read issue; the registered stages carry it towards WEn.
    assign issueVec = {issuePipe, (state == READ)};
    assign wEnNext  = issueVec[RL-1];

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state     <= IDLE;
            srcQ      <= '0;
            dstQ      <= '0;
            lenQ      <= '0;
            rdIdx     <= '0;
            wrIdx     <= '0;
            rAddrQ    <= '0;
            wAddrQ    <= '0;
            issuePipe <= '0;
            busyQ     <= 1'b0;
            doneQ     <= 1'b0;
        end else begin
            state     <= stateNext;
            srcQ      <= srcNext;
            dstQ      <= dstNext;
            lenQ      <= lenNext;
            rdIdx     <= rdIdxNext;
            wrIdx     <= wrIdxNext;
            rAddrQ    <= rAddrNext;
            wAddrQ    <= wAddrNext;
            issuePipe <= issueVec[RL-1:0];
            busyQ     <= busyNext;
            doneQ     <= doneNext;
        end
    end

    always_comb begin
        stateNext = state;
        srcNext   = srcQ;
        dstNext   = dstQ;
        lenNext   = lenQ;
        rdIdxNext = rdIdx;
        wrIdxNext = wrIdx;
        rAddrNext = '0;
        wAddrNext = '0;

        // Write side follows the delayed issue flag; address counts completed writes.
        if (wEnNext) begin
            wAddrNext = dstQ + wrIdx;
            wrIdxNext = wrIdx + AW'(1);
        end

        unique case (state)
            IDLE: begin
                if (bus.Start) begin
                    srcNext   = bus.SrcBase;
                    dstNext   = bus.DstBase;
                    lenNext   = bus.Length;
                    rdIdxNext = '0;
                    wrIdxNext = '0;
                    if (bus.Length != '0) begin
                        stateNext = READ;
                        rAddrNext = bus.SrcBase;
                    end else begin
                        stateNext = DONE;
                    end
                end
            end
            READ: begin
                if (rdIdx == lenQ - AW'(1)) begin
                    stateNext = DRAIN;
                end else begin
                    rAddrNext = srcQ + rdIdx + AW'(1);
                    rdIdxNext = rdIdx + AW'(1);
                end
            end
            DRAIN: begin
                // Only the output stage may still hold a flag: this cycle carries the last WEn.
                if (issueVec[RL-1:0] == '0) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        busyNext = (stateNext != IDLE);
        doneNext = (stateNext == DONE);
    end

    assign bus.RAddr = rAddrQ;
    assign bus.WAddr = wAddrQ;
    assign bus.WEn   = issuePipe[RL];
    assign bus.Busy  = busyQ;
    assign bus.Done  = doneQ;
endmodule

// File: tb/tb_mem_copy_ctrl.sv
// Scoreboard bench for mem_copy_ctrl at read latencies 1 and 3: a transaction-level model
// predicts every read, write, Busy window and Done cycle; a per-cycle monitor compares.
module tb_mem_copy_ctrl;
    localparam int unsigned AW      = 32;
    localparam int unsigned NumRand = 40;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned passes = 0;

    task automatic check(input string name, input int lat, input logic [AW-1:0] act,
                         input logic [AW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s lat=%0d t=%0t got %h expected %h", name, lat, $time, act, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : gInst
        localparam int unsigned Lat = (g == 0) ? 1 : 3;

        logic aclr;
        logic finished = 1'b0;
        int   cyc = 0;
        ev_t  readQ[$];
        ev_t  writeQ[$];
        int   doneQ[$];
        int   busyLo[$];
        int   busyHi[$];

        mem_copy_ctrl_if #(.AddressWidth(AW)) bus ();

        mem_copy_ctrl #(.AddressWidth(AW), .ReadLatency(Lat)) dut (
            .clk (clk),
            .aclr(aclr),
            .bus (bus.slave)
        );

        always @(posedge clk) cyc <= cyc + 1;

        // Reference model of one accepted copy starting in cycle s (Start high in cycle s).
        task automatic model(input int s, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                             input int len, output int d);
            for (int i = 0; i < len; i++) begin
                readQ.push_back('{s + 1 + i, src + AW'(i)});
                writeQ.push_back('{s + 1 + i + int'(Lat), dst + AW'(i)});
            end
            d = (len == 0) ? s + 1 : s + len + int'(Lat) + 1;
            doneQ.push_back(d);
            busyLo.push_back(s + 1);
            busyHi.push_back(d);
        endtask

        always @(negedge clk) begin : mon
            logic [AW-1:0] expR, expW;
            logic          expWe, expDone, expBusy;
            expR = '0; expW = '0; expWe = 1'b0; expDone = 1'b0;
            if (readQ.size() > 0 && readQ[0].cyc == cyc) begin
                expR = readQ[0].addr;
                void'(readQ.pop_front());
            end
            if (writeQ.size() > 0 && writeQ[0].cyc == cyc) begin
                expW  = writeQ[0].addr;
                expWe = 1'b1;
                void'(writeQ.pop_front());
            end
            if (doneQ.size() > 0 && doneQ[0] == cyc) begin
                expDone = 1'b1;
                void'(doneQ.pop_front());
            end
            while (busyHi.size() > 0 && busyHi[0] < cyc) begin
                void'(busyHi.pop_front());
                void'(busyLo.pop_front());
            end
            expBusy = (busyLo.size() > 0) && (busyLo[0] <= cyc) && (cyc <= busyHi[0]);
            check("RAddr", Lat, bus.RAddr, expR);
            check("WAddr", Lat, bus.WAddr, expW);
            check("WEn",   Lat, AW'(bus.WEn),  AW'(expWe));
            check("Busy",  Lat, AW'(bus.Busy), AW'(expBusy));
            check("Done",  Lat, AW'(bus.Done), AW'(expDone));
        end

        initial begin : drv
            int s, d, spurCyc, gap, len;
            logic [AW-1:0] src, dst;
            aclr = 1'b1;
            bus.Start = 1'b0; bus.SrcBase = '0; bus.DstBase = '0; bus.Length = '0;
            repeat (3) @(posedge clk);
            #1 aclr = 1'b0;
            @(posedge clk); #1;

            for (int j = 0; j < 5 + int'(NumRand); j++) begin
                spurCyc = -1;
                case (j)
                    0: begin src = 32'h10; dst = 32'h80; len = 4; gap = 2; end
                    1: begin src = 32'h55; dst = 32'h66; len = 0; gap = 1; end
                    2: begin src = 32'hFFFF_FFFE; dst = 32'hFFFF_FFFF; len = 3; gap = 0; end
                    3: begin src = 32'h10; dst = 32'h80; len = 4; gap = 3; end
                    4: begin src = 32'h200; dst = 32'h300; len = 1; gap = 0; end
                    default: begin
                        src = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - AW'($urandom_range(0, 3))
                                                          : AW'($urandom);
                        dst = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - AW'($urandom_range(0, 3))
                                                          : AW'($urandom);
                        len = int'($urandom_range(0, 6));
                        gap = int'($urandom_range(0, 2));
                    end
                endcase
                s = cyc;
                bus.Start = 1'b1; bus.SrcBase = src; bus.DstBase = dst; bus.Length = AW'(len);
                model(s, src, dst, len, d);
                if (j == 2) spurCyc = s + 1;
                else if (j >= 5 && $urandom_range(0, 1) == 1) spurCyc = int'($urandom_range(d, s + 1));
                while (cyc < d + 1 + gap) begin
                    @(posedge clk); #1;
                    if (cyc == spurCyc) begin
                        bus.Start = 1'b1; bus.SrcBase = ~src; bus.DstBase = src;
                        bus.Length = AW'(len + 5);
                    end else begin
                        bus.Start = 1'b0; bus.SrcBase = AW'($urandom);
                        bus.DstBase = AW'($urandom); bus.Length = AW'($urandom);
                    end
                end
            end

            // Abort a Len=8 copy in the cycle after its second write.
            s = cyc;
            src = 32'h1000; dst = 32'h2000;
            bus.Start = 1'b1; bus.SrcBase = src; bus.DstBase = dst; bus.Length = AW'(8);
            for (int i = 0; i <= int'(Lat) + 1; i++) readQ.push_back('{s + 1 + i, src + AW'(i)});
            for (int i = 0; i < 2; i++) writeQ.push_back('{s + 1 + i + int'(Lat), dst + AW'(i)});
            busyLo.push_back(s + 1);
            busyHi.push_back(s + 2 + int'(Lat));
            while (cyc < s + 3 + int'(Lat)) begin
                @(posedge clk); #1;
                bus.Start = 1'b0;
            end
            #1 aclr = 1'b1;
            #1;
            check("abort RAddr", Lat, bus.RAddr, '0);
            check("abort WAddr", Lat, bus.WAddr, '0);
            check("abort WEn",   Lat, AW'(bus.WEn),  '0);
            check("abort Busy",  Lat, AW'(bus.Busy), '0);
            check("abort Done",  Lat, AW'(bus.Done), '0);
            repeat (2) @(posedge clk);
            #1 aclr = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            s = cyc;
            bus.Start = 1'b1; bus.SrcBase = 32'h40; bus.DstBase = 32'h50; bus.Length = AW'(2);
            model(s, 32'h40, 32'h50, 2, d);
            while (cyc < d + 3) begin
                @(posedge clk); #1;
                bus.Start = 1'b0;
            end
            check("scoreboard drained", Lat,
                  AW'(readQ.size() + writeQ.size() + doneQ.size()), '0);
            finished = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

    initial begin
        wait (gInst[0].finished && gInst[1].finished);
        @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mem_copy_ctrl.md
MEM_COPY_CTRL -- requirements
Module: mem_copy_ctrl

Interface
REQ-001 Parameter AddressWidth, default 32: width of all address and length fields.
REQ-002 Parameter ReadLatency, default 1: cycles from RAddr presented to RAM q valid; legal range 1..4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 aclr  input  1  asynchronous, active-high reset.
REQ-005 Start  input  1  one-cycle request to begin a block copy; sampled only in IDLE.
REQ-006 SrcBase  input  AddressWidth  first source (read) address; latched on accepted Start.
REQ-007 DstBase  input  AddressWidth  first destination (write) address; latched on accepted Start.
REQ-008 Length  input  AddressWidth  number of words to copy; latched on accepted Start.
REQ-009 RAddr  output  AddressWidth  read address to source RAM.
REQ-010 WAddr  output  AddressWidth  write address to destination RAM.
REQ-011 WEn  output  1  write enable to destination RAM; data path is source q wired directly to destination data.
REQ-012 Busy  output  1  high from accepted Start until Done cycle inclusive.
REQ-013 Done  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL implement states IDLE, READ, DRAIN, DONE.
REQ-015 IDLE: Start=1 latches SrcBase, DstBase and Length; next state READ if Length!=0, else DONE.
REQ-016 Start in any state other than IDLE SHALL be ignored; latched values SHALL NOT change.
REQ-017 READ: each cycle SHALL drive RAddr=Src+i for i=0..Length-1, one address per cycle with no bubbles; after i=Length-1, next state DRAIN.
REQ-018 A read-issue flag SHALL pass through a ReadLatency-deep shift register; WEn SHALL equal the register output.
REQ-019 WAddr SHALL be Dst+j, where j counts asserted WEn cycles from 0; WEn for word k SHALL occur exactly ReadLatency cycles after RAddr for word k.
REQ-020 DRAIN: SHALL remain until the shift register is empty and the final WEn has occurred, then go to DONE.
REQ-021 DONE: Done=1 for exactly one cycle, then IDLE; Done SHALL occur the cycle after the last WEn (or the cycle after Start for Length=0).
REQ-022 Address arithmetic SHALL be modulo 2^AddressWidth; Src+i and Dst+j wrap silently.
REQ-023 RAddr SHALL be 0 outside READ; WAddr SHALL be 0 when WEn=0.
REQ-024 Busy SHALL be high in READ, DRAIN and DONE, and low in IDLE.
REQ-025 Total latency, Start to Done: 1+Length+ReadLatency cycles for Length>0; 1 cycle for Length=0.
REQ-026 A new Start SHALL be accepted in the IDLE cycle immediately following Done.

Reset
REQ-027 aclr=1 SHALL asynchronously force state to IDLE, clear the shift register, counters and latched fields, and force RAddr=0, WAddr=0, WEn=0, Busy=0, Done=0.
REQ-028 aclr asserted mid-copy SHALL abort with no further WEn or Done; the next Start after release SHALL begin a fresh copy.

Verification
REQ-029 ReadLatency=1, Start with Src=0x10, Dst=0x80, Len=4 -> RAddr 0x10..0x13 in cycles 1-4, WEn with WAddr 0x80..0x83 in cycles 2-5, Done in cycle 6, Busy high in cycles 1-6.
REQ-030 Len=0, Start -> no RAddr/WEn activity, Done in cycle 1, Busy high in cycle 1 only.
REQ-031 ReadLatency=3, Src=0xFFFFFFFE, Dst=0xFFFFFFFF, Len=3 -> RAddr FFFFFFFE, FFFFFFFF, 0; WAddr FFFFFFFF, 0, 1, starting 3 cycles after the first RAddr; Done 1 cycle after the last WEn.
REQ-032 Start pulsed again during READ with different bases -> ignored; original addresses complete unchanged; a single Done.
REQ-033 aclr asserted after the 2nd WEn of a Len=8 copy -> all outputs 0 immediately, no Done; Start Len=2 after release -> correct 2-word copy.
REQ-034 Back-to-back: Start on the cycle after Done -> accepted; second copy timing identical to the first.
